agc_gain_sequencer: RTL
=======================

# agc_gain_sequencer

Sequences gain changes requested by the automatic gain controller onto the analog front-end PGA. Per change: break-before-make mute, gain code update, blanking of ADC samples during settling, and a minimum dwell time before the next change is accepted, which prevents gain chatter. Sits between the AGC decision logic and the ADC sample stream. Downstream sees only samples taken at a settled, known gain, each tagged with that gain.

## Interface
- `DATA_W`, 12, ADC sample width.
- `GAIN_W`, 2, gain code width.
- `MAX_GAIN`, 3, highest legal gain code; requests above it are clamped.
- `INIT_GAIN`, 0, gain code driven from reset.
- `MUTE_CYCLES`, 4, clk cycles `pga_mute` is held before the gain code changes; must be ≥1.
- `SETTLE_SAMPLES`, 16, ADC strobes blanked after the change; 0 skips settling.
- `DWELL_SAMPLES`, 256, ADC strobes after settling before the next request is accepted.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `adc_en` in 1: one-clk strobe per new ADC sample.
- `adc_data` in DATA_W: sample, valid when `adc_en`=1.
- `req_valid` in 1: gain change request.
- `req_gain` in GAIN_W: requested gain code.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `pga_gain` out GAIN_W: gain code to the PGA.
- `pga_mute` out 1: PGA input mute.
- `out_valid` out 1: downstream sample strobe.
- `out_data` out DATA_W: forwarded sample.
- `out_gain` out GAIN_W: gain in effect for `out_data`.
- `blanking` out 1: high in every state except RUN.

## Operation
- States: RUN, MUTE, SWITCH, SETTLE. Reset state is RUN.
- **RUN**
  - Samples pass through.
  - `req_ready` = `dwell_cnt`==0.
  - On accept, target = min(`req_gain`, MAX_GAIN).
  - If target == `pga_gain`: accept and drop, stay in RUN, no dwell reload.
  - Otherwise go to MUTE.
- **MUTE**
  - `pga_mute`=1.
  - Counts MUTE_CYCLES clk cycles, then goes to SWITCH.
- **SWITCH**
  - One cycle. `pga_gain` <= target while `pga_mute` stays 1.
  - Next state is SETTLE, or RUN if SETTLE_SAMPLES=0.
- **SETTLE**
  - `pga_mute`=0.
  - Counts `adc_en` strobes. After SETTLE_SAMPLES strobes, go to RUN and load `dwell_cnt`=DWELL_SAMPLES.
- **Dwell counter**
  - Decrements on each `adc_en` in RUN and saturates at 0.
- **Sample gating**
  - `adc_en` outside RUN produces no `out_valid`; the sample is discarded.
- **Counter widths**
  - Each counter is `$clog2(param+1)` bits.
  - No wrap: counters stop at their terminal value.

## Timing
- **Reset values:** `pga_gain`=INIT_GAIN, `pga_mute`=0, `out_valid`=0, `out_data`=0, `out_gain`=INIT_GAIN, `blanking`=0, `dwell_cnt`=0 (so `req_ready`=1).
- **Output latency:** `out_valid`/`out_data`/`out_gain` are registered, 1 clk after `adc_en`.
- **Registered controls:** `pga_mute` and `blanking` are registered and assert 1 clk after the accept edge. `pga_gain` changes on the clk edge ending SWITCH.
- **Gain change, SETTLE_SAMPLES>0:** accept→`pga_gain` change takes MUTE_CYCLES+1 clk.
- **Simultaneous accept and `adc_en` in RUN:** that sample is forwarded with the old gain.
- **`adc_en` on the cycle SETTLE exits:** it counts as the last settle strobe and is not forwarded. Forwarding resumes with the next strobe.
- **`req_valid` while `req_ready`=0:** ignored. The requester holds it; no queueing.
- **`rst` mid-sequence:** immediate return to reset values. `pga_gain` reverts to INIT_GAIN asynchronously.

## Configuration
- `AGC_SEQ_STATS_EN` defined:
  - Adds `switch_count` out 16 (gain changes completed, i.e. SWITCH entries).
  - Adds `drop_count` out 16 (`adc_en` strobes discarded outside RUN).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** Reset, then 5 idle clk → `pga_gain`=0, `pga_mute`=0, `req_ready`=1, `out_valid`=0.
- **Steady RUN:** `adc_en` every 20 clk with data 0x7FF → `out_valid` 1 clk after each strobe, `out_data`=0x7FF, `out_gain`=0.
- **Gain change 0→2** (defaults):
  - `pga_mute` high 5 clk.
  - `pga_gain`=2 at accept+5.
  - Next 16 strobes give no `out_valid`; the 17th is forwarded with `out_gain`=2.
  - `req_ready` stays low for the following 256 strobes.
- **Same gain / clamp:**
  - `req_gain`=0 at `pga_gain`=0 → accepted, no mute, `req_ready` stays 1.
  - `req_gain`=3 with MAX_GAIN=2 → `pga_gain`=2.
- **Reset mid-sequence:** `rst` pulse 3 clk into SETTLE → `pga_gain`=0 and `blanking`=0 immediately; next strobe forwarded.
- **Stats** (`AGC_SEQ_STATS_EN` defined): 3 gain changes → `switch_count`=3, `drop_count`=48 with SETTLE_SAMPLES=16 and no strobes during MUTE.

Source files
------------

// File: rtl/agc_gain_sequencer_if.sv
// agc_gain_sequencer_if: AGC request, ADC sample stream and PGA control bundle.
// The master side is the AGC logic plus ADC; the slave side is the sequencer.
interface agc_gain_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int GAIN_W = 2
);
  logic              adc_en;
  logic [DATA_W-1:0] adc_data;
  logic              req_valid;
  logic [GAIN_W-1:0] req_gain;
  logic              req_ready;
  logic [GAIN_W-1:0] pga_gain;
  logic              pga_mute;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [GAIN_W-1:0] out_gain;
  logic              blanking;

  modport master (
    output adc_en, adc_data, req_valid, req_gain,
    input  req_ready, pga_gain, pga_mute, out_valid, out_data, out_gain, blanking
  );

  modport slave (
    input  adc_en, adc_data, req_valid, req_gain,
    output req_ready, pga_gain, pga_mute, out_valid, out_data, out_gain, blanking
  );
endinterface

// File: rtl/agc_gain_sequencer.sv
// agc_gain_sequencer: applies AGC gain requests to the PGA with a
// break-before-make mute, blanks ADC samples while the PGA settles, and
// enforces a dwell (in ADC strobes) before another change is accepted.
// Optional statistics counters: define AGC_SEQ_STATS_EN.
module agc_gain_sequencer #(
  parameter int DATA_W         = 12,
  parameter int GAIN_W         = 2,
  parameter int MAX_GAIN       = 3,
  parameter int INIT_GAIN      = 0,
  parameter int MUTE_CYCLES    = 4,
  parameter int SETTLE_SAMPLES = 16,
  parameter int DWELL_SAMPLES  = 256
) (
  input  logic clk,
  input  logic rst,
  agc_gain_sequencer_if.slave bus
`ifdef AGC_SEQ_STATS_EN
  ,
  output logic [15:0] switch_count,
  output logic [15:0] drop_count
`endif
);
  // Counter widths; zero-length parameters still get a 1-bit counter.
  localparam int MW = $clog2(MUTE_CYCLES + 1);
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int DW = (DWELL_SAMPLES > 0) ? $clog2(DWELL_SAMPLES + 1) : 1;
  localparam int SETTLE_LAST = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam logic [GAIN_W:0]   MAXG_EXT   = (GAIN_W + 1)'(MAX_GAIN);
  localparam logic [GAIN_W-1:0] INIT_G     = GAIN_W'(INIT_GAIN);
  localparam logic [DW-1:0]     DWELL_LOAD = DW'(DWELL_SAMPLES);

  typedef enum logic [1:0] {RUN, MUTE, SWITCH, SETTLE} state_t;

  state_t            state, state_n;
  logic [MW-1:0]     mute_cnt;
  logic [SW-1:0]     settle_cnt;
  logic [DW-1:0]     dwell_cnt;
  logic [GAIN_W-1:0] tgt_q, req_tgt, pga_gain_q, out_gain_q;
  logic [DATA_W-1:0] out_data_q;
  logic              pga_mute_q, blanking_q, out_valid_q;
  logic              ready, accept, change, mute_last, settle_last, fwd;

  // Requests above the legal range are clamped rather than rejected.
  assign req_tgt     = ({1'b0, bus.req_gain} > MAXG_EXT) ? MAXG_EXT[GAIN_W-1:0] : bus.req_gain;
  assign ready       = (state == RUN) && (dwell_cnt == '0);
  assign accept      = bus.req_valid && ready;
  assign change      = accept && (req_tgt != pga_gain_q);
  assign mute_last   = (mute_cnt == MW'(MUTE_CYCLES - 1));
  assign settle_last = (settle_cnt == SW'(SETTLE_LAST));
  assign fwd         = bus.adc_en && (state == RUN);

  assign bus.req_ready = ready;
  assign bus.pga_gain  = pga_gain_q;
  assign bus.pga_mute  = pga_mute_q;
  assign bus.blanking  = blanking_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_gain  = out_gain_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // Next-state: a same-gain request is absorbed in RUN without a sequence.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (change) state_n = MUTE;
      MUTE:    if (mute_last) state_n = SWITCH;
      SWITCH:  state_n = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      SETTLE:  if (bus.adc_en && settle_last) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Sequencing counters, target latch, PGA gain and registered mute/blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mute_cnt   <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      tgt_q      <= INIT_G;
      pga_gain_q <= INIT_G;
      pga_mute_q <= 1'b0;
      blanking_q <= 1'b0;
    end else begin
      pga_mute_q <= (state_n == MUTE) || (state_n == SWITCH);
      blanking_q <= (state_n != RUN);
      case (state)
        RUN: begin
          if (change) begin
            tgt_q    <= req_tgt;
            mute_cnt <= '0;
          end
          if (bus.adc_en && dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
        end
        MUTE: if (!mute_last) mute_cnt <= mute_cnt + 1'b1;
        SWITCH: begin
          pga_gain_q <= tgt_q;
          settle_cnt <= '0;
          if (SETTLE_SAMPLES == 0) dwell_cnt <= DWELL_LOAD;
        end
        SETTLE: if (bus.adc_en) begin
          // The exiting strobe is the last blanked one; dwell starts after it.
          if (settle_last) dwell_cnt  <= DWELL_LOAD;
          else             settle_cnt <= settle_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output sample register: forward only RUN samples, tagged with the live gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_gain_q  <= INIT_G;
    end else begin
      out_valid_q <= fwd;
      if (fwd) begin
        out_data_q <= bus.adc_data;
        out_gain_q <= pga_gain_q;
      end
    end
  end

`ifdef AGC_SEQ_STATS_EN
  // Saturating counts of SWITCH entries and strobes discarded outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch_count <= '0;
      drop_count   <= '0;
    end else begin
      if (state == MUTE && mute_last && switch_count != 16'hFFFF) switch_count <= switch_count + 1'b1;
      if (bus.adc_en && state != RUN && drop_count != 16'hFFFF)   drop_count   <= drop_count + 1'b1;
    end
  end
`endif
endmodule
